rr_arb_mux: RTL and testbench

- Parametrised N-input, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Selection is round-robin by default, or fixed-priority when configured.
- Output goes through a single registered stage that supports full throughput (one transfer per cycle).
- Used to merge multiple pipeline request streams (e.g. fetch/load/store traffic) onto one shared bus or port.

---
 rtl/rr_arb_mux.sv | 95 +++++++++
 tb/tb_rr_arb_mux.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-input registered valid/ready multiplexer with round-robin or fixed-priority arbitration.
// A single output register supports full throughput (drain and load on the same edge).
module rr_arb_mux #(
  parameter int N          = 4,
  parameter int WIDTH      = 64,
  parameter int SEL_W      = $clog2(N),
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             can_load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin : grant_search
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    if (FIXED_PRIO) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = (int'(last_q) + k) % N;
        if (in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    can_load   = !out_valid_q || out_ready;
    xfer       = !reset && can_load && grant_vld;
    in_ready   = xfer ? (N'(1) << grant) : '0;
    grant_data = in_data[grant*WIDTH +: WIDTH];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (can_load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_sel_d  = grant;
        last_d     = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: round-robin N=4, fixed-priority N=4 and round-robin N=3 instances.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [3:0]   a_in_valid, a_in_ready;
  logic [255:0] a_in_data;
  logic         a_out_valid, a_out_ready;
  logic [63:0]  a_out_data;
  logic [1:0]   a_out_sel;

  logic [3:0]   b_in_valid, b_in_ready;
  logic [255:0] b_in_data;
  logic         b_out_valid, b_out_ready;
  logic [63:0]  b_out_data;
  logic [1:0]   b_out_sel;

  logic [2:0]   c_in_valid, c_in_ready;
  logic [47:0]  c_in_data;
  logic         c_out_valid, c_out_ready;
  logic [15:0]  c_out_data;
  logic [1:0]   c_out_sel;

  rr_arb_mux #(.N(4), .WIDTH(64), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_ready(a_out_ready));

  rr_arb_mux #(.N(4), .WIDTH(64), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_ready(b_out_ready));

  rr_arb_mux #(.N(3), .WIDTH(16), .FIXED_PRIO(1'b0)) u_n3 (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_ready(c_out_ready));

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [63:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  function automatic exp_t mk(input int s, input logic [63:0] d);
    exp_t e;
    e.sel  = 4'(s);
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expected entry per completed output handshake.
  always @(negedge clk) begin : mon_a
    exp_t e;
    chk("a_in_ready_onehot0", 64'($onehot0(a_in_ready)), 64'd1);
    if (!reset && a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL a_unexpected_out: got sel=%0d data=0x%0h, expected no output", a_out_sel, a_out_data);
      end else begin
        e = q_a.pop_front();
        chk("a_out_sel", 64'(a_out_sel), 64'(e.sel));
        chk("a_out_data", a_out_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL b_unexpected_out: got sel=%0d data=0x%0h, expected no output", b_out_sel, b_out_data);
      end else begin
        e = q_b.pop_front();
        chk("b_out_sel", 64'(b_out_sel), 64'(e.sel));
        chk("b_out_data", b_out_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    chk("c_out_sel_lt_n", 64'(c_out_sel < 2'd3), 64'd1);
    if (!reset && c_out_valid && c_out_ready) begin
      if (q_c.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL c_unexpected_out: got sel=%0d data=0x%0h, expected no output", c_out_sel, c_out_data);
      end else begin
        e = q_c.pop_front();
        chk("c_out_sel", 64'(c_out_sel), 64'(e.sel));
        chk("c_out_data", 64'(c_out_data), e.data);
      end
    end
  end

  // Producers on the round-robin instance must hold valid/data until accepted.
  for (genvar i = 0; i < 4; i++) begin : g_hold
    assert property (@(posedge clk) disable iff (reset)
      (a_in_valid[i] && !a_in_ready[i]) |=> (a_in_valid[i] && $stable(a_in_data[i*64 +: 64])))
      else $error("input hold rule broken on channel %0d", i);
  end

  initial begin
    reset       = 1'b1;
    a_in_valid  = 4'hF;
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) a_in_data[k*64 +: 64] = 64'h10 + 64'(k);
    b_in_valid  = '0;
    b_in_data   = '0;
    b_out_ready = 1'b1;
    c_in_valid  = '0;
    c_in_data   = '0;
    c_out_ready = 1'b1;

    // Reset state, with all requests asserted.
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 64'(a_in_ready), 64'h0);
    chk("rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("rst_out_data", a_out_data, 64'h0);
    chk("rst_out_sel", 64'(a_out_sel), 64'h0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'h0);
    chk("rst_c_out_valid", 64'(c_out_valid), 64'h0);

    // All channels valid: 0,1,2,3,0,1,2,3; each channel drops after its second grant.
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) q_a.push_back(mk(k % 4, 64'h10 + 64'(k % 4)));
    @(negedge clk);
    chk("rr_first_in_ready", 64'(a_in_ready), 64'h1);
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      step();
      a_in_valid[k] = 1'b0;
    end
    step();
    @(negedge clk);
    chk("rr_idle_out_valid", 64'(a_out_valid), 64'h0);

    // Single channel 2 with X on the other lanes.
    step();
    a_in_data = 'x;
    a_in_data[2*64 +: 64] = 64'hDEAD;
    a_in_valid = 4'b0100;
    q_a.push_back(mk(2, 64'hDEAD));
    @(negedge clk);
    chk("ch2_in_ready", 64'(a_in_ready), 64'h4);
    step();
    a_in_valid = 4'b0000;
    @(negedge clk);
    chk("ch2_out_valid", 64'(a_out_valid), 64'h1);
    step();
    @(negedge clk);
    chk("ch2_drop_out_valid", 64'(a_out_valid), 64'h0);

    // Stall: channels 1 and 3 from a fresh reset, out_ready low for 3 cycles.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_in_data = '0;
    a_in_data[1*64 +: 64] = 64'h111;
    a_in_data[3*64 +: 64] = 64'h333;
    a_in_valid  = 4'b1010;
    a_out_ready = 1'b0;
    q_a.push_back(mk(1, 64'h111));
    q_a.push_back(mk(3, 64'h333));
    @(negedge clk);
    chk("stall_first_in_ready", 64'(a_in_ready), 64'h2);
    step();
    a_in_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(a_out_valid), 64'h1);
      chk("stall_out_data", a_out_data, 64'h111);
      chk("stall_out_sel", 64'(a_out_sel), 64'h1);
      chk("stall_in_ready", 64'(a_in_ready), 64'h0);
      step();
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("drain_load_in_ready", 64'(a_in_ready), 64'h8);
    step();
    a_in_valid = 4'b0000;
    step();
    @(negedge clk);
    chk("stall_end_out_valid", 64'(a_out_valid), 64'h0);

    // Reset while 0xBEEF is held in the output register.
    step();
    a_out_ready = 1'b0;
    a_in_valid  = 4'b1000;
    a_in_data[3*64 +: 64] = 64'hBEEF;
    step();
    a_in_data[0*64 +: 64] = 64'h20;
    a_in_data[1*64 +: 64] = 64'h21;
    a_in_data[2*64 +: 64] = 64'h22;
    a_in_data[3*64 +: 64] = 64'h33;
    a_in_valid = 4'b1111;
    reset = 1'b1;
    @(negedge clk);
    chk("beef_held_valid", 64'(a_out_valid), 64'h1);
    chk("beef_held_data", a_out_data, 64'hBEEF);
    chk("beef_rst_in_ready", 64'(a_in_ready), 64'h0);
    step();
    reset = 1'b0;
    a_out_ready = 1'b1;
    q_a.push_back(mk(0, 64'h20));
    q_a.push_back(mk(1, 64'h21));
    q_a.push_back(mk(2, 64'h22));
    q_a.push_back(mk(3, 64'h33));
    @(negedge clk);
    chk("post_rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("post_rst_in_ready", 64'(a_in_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      a_in_valid[k] = 1'b0;
    end
    step();
    @(negedge clk);
    chk("post_rst_idle", 64'(a_out_valid), 64'h0);

    // Fixed priority: channels 0 and 2 always valid, channel 0 wins every cycle.
    step();
    b_in_data[0*64 +: 64] = 64'hA0;
    b_in_data[2*64 +: 64] = 64'hA2;
    b_in_valid = 4'b0101;
    for (int k = 0; k < 5; k++) q_b.push_back(mk(0, 64'hA0));
    @(negedge clk);
    chk("fp_in_ready", 64'(b_in_ready), 64'h1);
    repeat (5) step();
    b_in_valid = 4'b0000;
    step();
    @(negedge clk);
    chk("fp_idle_out_valid", 64'(b_out_valid), 64'h0);

    // N=3: channel 2 first leaves last=2, then 1 and 2 alternate.
    step();
    c_in_data[2*16 +: 16] = 16'h0002;
    c_in_valid = 3'b100;
    q_c.push_back(mk(2, 64'h2));
    step();
    c_in_data[1*16 +: 16] = 16'h0011;
    c_in_data[2*16 +: 16] = 16'h0022;
    c_in_valid = 3'b110;
    q_c.push_back(mk(1, 64'h11));
    q_c.push_back(mk(2, 64'h22));
    q_c.push_back(mk(1, 64'h11));
    q_c.push_back(mk(2, 64'h22));
    @(negedge clk);
    chk("n3_in_ready", 64'(c_in_ready), 64'h2);
    repeat (4) step();
    c_in_valid = 3'b000;
    step();
    @(negedge clk);
    chk("n3_idle_out_valid", 64'(c_out_valid), 64'h0);

    step();
    chk("a_queue_left", 64'(q_a.size()), 64'h0);
    chk("b_queue_left", 64'(q_b.size()), 64'h0);
    chk("c_queue_left", 64'(q_c.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
